// File: rtl/wb_shared_bus.sv
// Single-master Wishbone shared bus: decodes one master request to one of NUM_SLAVES slaves and returns its response.
// Optional watchdog (macro WB_BUS_TIMEOUT_EN) errors a transfer after TIMEOUT_CYCLES cycles in ACTIVE.
module wb_shared_bus #(
  parameter int                          NUM_SLAVES     = 2,
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_BASE     = {32'h0000_1000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_MASK     = {32'hFFFF_F000, 32'hFFFF_F000},
  parameter int                          TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      async_rst_i,
  input  logic [31:0]               m_adr_i,
  input  logic [31:0]               m_dat_i,
  output logic [31:0]               m_dat_o,
  input  logic                      m_we_i,
  input  logic [3:0]                m_sel_i,
  input  logic                      m_cyc_i,
  input  logic                      m_stb_i,
  input  logic                      m_lock_i,
  output logic                      m_ack_o,
  output logic                      m_err_o,
  output logic                      m_rty_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_lock_o,
  output logic [NUM_SLAVES-1:0]     s_cyc_o,
  output logic [NUM_SLAVES-1:0]     s_stb_o,
  input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]     s_ack_i,
  input  logic [NUM_SLAVES-1:0]     s_err_i,
  input  logic [NUM_SLAVES-1:0]     s_rty_i,
  output logic [15:0]               err_count_o,
  output logic                      busy_o
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, DERR} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slv_q, hit_idx;
  logic          hit_any;
  logic [31:0]   adr_q, wdat_q, rdat_q;
  logic          we_q, lock_q;
  logic [3:0]    sel_q;
  logic [2:0]    kind_q;  // one-hot {err, rty, ack}
  logic [15:0]   err_cnt_q;
  logic          req, sel_ack, sel_err, sel_rty, any_rsp, timeout;
  logic [31:0]   sel_rdat;

  assign req = m_cyc_i & m_stb_i;

  // Descending scan so the lowest hitting index is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr_i & SLAVE_MASK[32*i +: 32]) == (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    sel_ack  = 1'b0;
    sel_err  = 1'b0;
    sel_rty  = 1'b0;
    sel_rdat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_q == SW'(i)) begin
        sel_ack  = s_ack_i[i];
        sel_err  = s_err_i[i];
        sel_rty  = s_rty_i[i];
        sel_rdat = s_dat_i[32*i +: 32];
      end
    end
  end

  assign any_rsp = sel_ack | sel_err | sel_rty;

`ifdef WB_BUS_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i)               to_cnt_q <= '0;
    else if (state_q != ACTIVE)    to_cnt_q <= '0;
    else                           to_cnt_q <= to_cnt_q + 16'd1;
  end

  assign timeout = (state_q == ACTIVE) && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the parameter stays on the interface but never fires.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // A master abort beats a same-edge slave response or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = hit_any ? ACTIVE : DERR;
      ACTIVE:  begin
        if (!m_cyc_i)                state_d = IDLE;
        else if (any_rsp || timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      DERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      slv_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      lock_q    <= 1'b0;
      rdat_q    <= '0;
      kind_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        slv_q  <= hit_idx;
        adr_q  <= m_adr_i;
        wdat_q <= m_dat_i;
        we_q   <= m_we_i;
        sel_q  <= m_sel_i;
        lock_q <= m_lock_i;
        if (!hit_any) rdat_q <= '0;
      end
      if (state_q == ACTIVE && m_cyc_i) begin
        if (any_rsp) begin
          kind_q <= sel_err ? 3'b100 : (sel_rty ? 3'b010 : 3'b001);
          rdat_q <= sel_rdat;
        end else if (timeout) begin
          kind_q <= 3'b100;
          rdat_q <= '0;
        end
      end
      if (m_err_o && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  always_comb begin
    s_cyc_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_cyc_o[i] = (state_q == ACTIVE) && (slv_q == SW'(i));
    end
  end

  assign s_stb_o     = s_cyc_o;
  assign s_adr_o     = adr_q;
  assign s_dat_o     = wdat_q;
  assign s_we_o      = we_q;
  assign s_sel_o     = sel_q;
  assign s_lock_o    = lock_q && (state_q == ACTIVE || state_q == RESP);
  assign m_dat_o     = rdat_q;
  assign m_ack_o     = (state_q == RESP) && kind_q[0];
  assign m_rty_o     = (state_q == RESP) && kind_q[1];
  assign m_err_o     = ((state_q == RESP) && kind_q[2]) || (state_q == DERR);
  assign err_count_o = err_cnt_q;
  assign busy_o      = (state_q != IDLE);

endmodule
